// File: rtl/map_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// map_mem_arbiter_if
//
// Bundles the requester-side and memory-side buses of the tile-map arbiter.
//
//   slave  : the arbiter. It takes in the requests and the memory read data.
//            It drives the grants, the read return and the memory port.
//   master : the surrounding system. This is the requesters plus the map RAM.
//
// Requester signals (packed, requester i in slice i):
//   req     per-requester access request
//   lock    per-requester hold-ownership request
//   addr    addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   we      write enable, qualified by req
//   wdata   write data, requester i at [i*DATA_W +: DATA_W]
//   gnt     one-hot-or-zero grant, combinational
//   rvalid  one-hot-or-zero read-data-valid, registered
//   rdata   broadcast read data, meaningful only where rvalid is set
// Memory port signals:
//   mem_addr, mem_we, mem_wdata : toward the RAM
//   mem_rdata : from the RAM, valid the cycle after mem_addr
// -----------------------------------------------------------------------------
interface map_mem_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_W     = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*DATA_W-1:0]     wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_W-1:0]             rdata;

    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_we;
    logic [DATA_W-1:0]             mem_wdata;
    logic [DATA_W-1:0]             mem_rdata;

    modport slave (
        input  req, lock, addr, we, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, lock, addr, we, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/map_mem_arbiter.sv
// -----------------------------------------------------------------------------
// map_mem_arbiter
//
// Shares the single port of the tile-map RAM between several requesters:
//   - the obstacle checkers
//   - the bomb/explosion updater
//   - the renderer
// The RAM has NUM_ROW x NUM_COL entries of DATA_W bits and a 1-cycle
// synchronous read. The arbiter grants one access per cycle, in round-robin
// order. A requester that raises lock keeps exclusive ownership for up to
// MAX_LOCK consecutive cycles. Read data comes back to the requester that
// issued the read, exactly one cycle after its grant.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous, active-low reset
//   bus    map_mem_arbiter_if.slave. It carries:
//            - req/lock/addr/we/wdata in
//            - gnt/rvalid/rdata out
//            - mem_addr/mem_we/mem_wdata out
//            - mem_rdata in
//
// Out-of-range addresses (>= NUM_ROW*NUM_COL) behave as follows:
//   - reads return OOB_CODE
//   - writes are granted, but the memory strobe is suppressed
// -----------------------------------------------------------------------------
module map_mem_arbiter #(
    parameter int                NUM_REQ  = 3,
    parameter int                NUM_ROW  = 11,
    parameter int                NUM_COL  = 19,
    parameter int                DATA_W   = 2,
    parameter int                MAX_LOCK = 8,
    parameter logic [DATA_W-1:0] OOB_CODE = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    map_mem_arbiter_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL);
    localparam int OWN_W      = $clog2(NUM_REQ);
    localparam int CNT_W      = $clog2(MAX_LOCK + 1);

    localparam logic [OWN_W-1:0]    LAST_IDX = OWN_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]    MAX_CNT  = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0]    ONE_CNT  = CNT_W'(1);
    // One extra bit, so that a map size equal to 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] MAP_SIZE = (ADDR_WIDTH + 1)'(NUM_ROW * NUM_COL);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [OWN_W-1:0]      last_owner;  // last granted requester; round-robin base
    logic                  locked;      // last_owner currently holds a lock
    logic [CNT_W-1:0]      lock_cnt;    // cycles spent in the current lock
    logic [NUM_REQ-1:0]    rd_owner;    // who gets the read data this cycle
    logic                  rd_oob;      // the pending read was out of range
    logic [ADDR_WIDTH-1:0] addr_q;      // mem_addr is held here while idle

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic                  hold;        // lock in force: only last_owner may win
    logic                  rr_found;
    logic [OWN_W-1:0]      rr_win;
    int                    scan_idx;
    logic [OWN_W-1:0]      win;
    logic                  gnt_ok;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_in_range;
    logic [CNT_W-1:0]      cnt_next;

    // The lock ends as soon as the owner drops lock. So, in the same cycle,
    // the others compete round-robin again and no dead cycle is left.
    assign hold     = locked && bus.lock[last_owner] && (lock_cnt < MAX_CNT);
    assign cnt_next = lock_cnt + ONE_CNT;

    // Round-robin scan, starting at last_owner+1 and wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every signal this block writes gets a default up front.
        // Without the default, a path that skips the assignment would infer a latch.
        rr_found = 1'b0;
        rr_win   = last_owner;
        scan_idx = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (int'(last_owner) + k) % NUM_REQ;
            if (!rr_found && bus.req[OWN_W'(scan_idx)]) begin
                rr_found = 1'b1;
                rr_win   = OWN_W'(scan_idx);
            end
        end
    end

    // The grant is gated by rst_n, so it drops the moment reset asserts.
    // It does not wait for the next clock edge.
    assign win    = hold ? last_owner : rr_win;
    assign gnt_ok = rst_n && (hold ? bus.req[last_owner] : rr_found);

    assign win_addr     = bus.addr[int'(win) * ADDR_WIDTH +: ADDR_WIDTH];
    assign win_in_range = {1'b0, win_addr} < MAP_SIZE;

    // -------------------------------------------------------------------------
    // Memory port and grant outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.gnt       = '0;
        bus.mem_addr  = addr_q;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (gnt_ok) begin
            bus.gnt[win]  = 1'b1;
            bus.mem_addr  = win_addr;
            bus.mem_we    = bus.we[win] && win_in_range;
            bus.mem_wdata = bus.wdata[int'(win) * DATA_W +: DATA_W];
        end
    end

    // Read return. rdata is forced to zero whenever no read is returning.
    // This also gives rdata its zero reset value.
    assign bus.rvalid = rd_owner;
    assign bus.rdata  = (|rd_owner) ? (rd_oob ? OOB_CODE : bus.mem_rdata) : '0;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= LAST_IDX;   // so that requester 0 wins first after reset
            locked     <= 1'b0;
            lock_cnt   <= '0;
            rd_owner   <= '0;
            rd_oob     <= 1'b0;
            addr_q     <= '0;
        end else begin
            // NOTE: state registers are updated with non-blocking assignments only.
            // Every read in this block therefore sees the values from before the edge.
            addr_q   <= bus.mem_addr;
            rd_owner <= '0;
            rd_oob   <= 1'b0;
            if (gnt_ok && !bus.we[win]) begin
                rd_owner[win] <= 1'b1;
                rd_oob        <= !win_in_range;
            end

            if (hold) begin
                // Idle cycles count as well, so a stalled owner cannot starve the others.
                if (cnt_next == MAX_CNT) begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= cnt_next;
                end
            end else if (gnt_ok) begin
                last_owner <= win;
                // With MAX_LOCK == 1 a single granted cycle already uses up the lock.
                if (bus.lock[win] && (MAX_CNT != ONE_CNT)) begin
                    locked   <= 1'b1;
                    lock_cnt <= ONE_CNT;
                end else begin
                    locked   <= 1'b0;
                    lock_cnt <= '0;
                end
            end else begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end
endmodule

// File: doc/map_mem_arbiter.md
# map_mem_arbiter

Shares the single port of the 19x11 tile-map memory (2-bit tile codes, 1-cycle synchronous read) between several requesters: the per-player obstacle checkers, the bomb/explosion updater and the renderer's tile fetch. Grants one access per cycle with round-robin fairness. A bounded lock lets a requester issue an uninterrupted burst, such as the multi-tile probe done per movement tick. Read data is returned to the requester that issued it, exactly one cycle after the grant.

## Interface
- NUM_REQ, 3, number of requesters (2..8); index 0 has first priority out of reset
- NUM_ROW, 11, map rows
- NUM_COL, 19, map columns
- DATA_W, 2, tile code width
- MAX_LOCK, 8, maximum consecutive granted cycles for one locked owner (>=1)
- OOB_CODE, 2'b11, tile code returned for out-of-range reads
- ADDR_WIDTH (localparam), $clog2(NUM_ROW*NUM_COL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester access request
- lock  in  NUM_REQ  per-requester hold-ownership request
- addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- we  in  NUM_REQ  write enable, qualified by req
- wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot-or-zero grant, combinational, same cycle as the accepted access
- rvalid  out  NUM_REQ  one-hot-or-zero read-data-valid, registered
- rdata  out  DATA_W  read data, broadcast; meaningful only where rvalid is set
- mem_addr  out  ADDR_WIDTH  memory address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_addr

## Operation
- State: last_owner pointer, locked flag, lock_cnt (width $clog2(MAX_LOCK+1)), a registered rd_owner one-hot, and an OOB flag.
- Arbitration is evaluated every cycle:
  - If locked and lock_cnt < MAX_LOCK, only last_owner can be granted. Others wait even if they request.
  - Otherwise the winner is the first asserted req scanning from last_owner+1 upward, wrapping modulo NUM_REQ.
- Grant: gnt[w]=req[w]. mem_addr=addr[w]. mem_we=we[w] & addr-in-range. mem_wdata=wdata[w].
- With no grant: mem_we=0 and mem_addr holds its previous value.
- Lock:
  - Granted with lock[w]=1: locked<=1, last_owner<=w, lock_cnt increments.
  - locked clears when lock[last_owner] drops, or when lock_cnt reaches MAX_LOCK. lock_cnt then clears and the next arbitration is round-robin from last_owner+1.
  - A locked owner with req=0 but lock=1 keeps ownership. Idle cycles count toward MAX_LOCK.
- Reads: when the grant has we=0, rvalid[w]=1 the next cycle. rdata=mem_rdata, or OOB_CODE if the address was >= NUM_ROW*NUM_COL.
- Writes: produce no rvalid. An out-of-range write is granted but suppressed (mem_we=0).

## Timing
- Reset (rst_n=0) values:
  - gnt=0, mem_we=0, rvalid=0 (gnt and mem_we forced low while rst_n is low)
  - mem_addr=0, rdata=0
  - last_owner=NUM_REQ-1, locked=0, lock_cnt=0
- Throughput is one access per cycle. Read latency is 1 cycle from the grant to rvalid.
- Deasserting rst_n mid-burst drops the lock and any pending rvalid. The first grant after release goes to the lowest-index requester.
- A read and a write in back-to-back cycles to the same address return the old data (the memory has no bypass).

## Test plan
- Single read: requester 1 reads addr 20 (mem holds 2'b10) -> gnt[1] in cycle 0; rvalid=3'b010 and rdata=2'b10 in cycle 1.
- Contention: req=3'b111 held for 6 cycles, no lock, from reset -> grant order 0,1,2,0,1,2. rvalid follows one cycle behind each read grant.
- Burst lock: requester 2 asserts lock with 4 reads while req[0] is held -> gnt[2] for 4 consecutive cycles. Lock drops, next gnt[0].
- Lock timeout: MAX_LOCK=8, requester 0 holds lock and req for 12 cycles while req[1]=1 -> gnt[0] for cycles 0-7, gnt[1] in cycle 8.
- Out of range: read addr 209 -> rvalid with rdata=2'b11. Write addr 215 -> gnt asserted, mem_we=0, no rvalid.
- Reset mid-burst: assert rst_n=0 during cycle 2 of a locked read burst -> gnt, rvalid and mem_we go 0 asynchronously. After release, req=3'b111 grants 0 first.
